// File: rtl/nfa_engine_param.sv
// nfa_engine_param: parameterised bit-parallel NFA matcher with a one-deep
// result handshake. Optional match counter enabled by macro NFA_MATCH_COUNT_EN;
// without it res_cnt is tied to 0 and no count register exists.
module nfa_engine_param #(
  parameter int unsigned              NSTATE      = 16,
  parameter int unsigned              NCLASS      = 24,
  parameter logic [NSTATE*6-1:0]      CLASS_SEL   = '0,
  parameter logic [NSTATE*NSTATE-1:0] PRED_MASK   = '0,
  parameter logic [NSTATE-1:0]        START_MASK  = '0,
  parameter logic [NSTATE-1:0]        SELF_MASK   = '0,
  parameter logic [NSTATE-1:0]        ACCEPT_MASK = '0,
  parameter bit                       ANCHORED    = 1'b0
) (
  input  logic              clk,
  input  logic              sod_n,
  input  logic              sod,
  input  logic              en,
  input  logic              eod,
  input  logic [NCLASS-1:0] cls,
  output logic              match,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_match,
  output logic [15:0]       res_pos,
  output logic [7:0]        res_cnt,
  output logic              res_drop
);

  localparam int unsigned POS_W  = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CLS_XW = 64;
  localparam logic [POS_W-1:0] POS_NONE = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NSTATE-1:0] s_q, s_d, s_cur, s_nxt, arm;
  logic [POS_W-1:0]  pos_q, pos_d, cur_pos, pos_inc;
  logic [POS_W-1:0]  fpos_q, fpos_d, fpos_cur, fpos_upd;
  logic              match_q, match_d, match_cur, match_upd;
  logic              hit;
  logic              res_valid_q, res_valid_d;
  logic              res_match_q, res_match_d;
  logic [POS_W-1:0]  res_pos_q, res_pos_d;
  logic              res_drop_q, res_drop_d;
  logic [CLS_XW-1:0] cls_ext;
`ifdef NFA_MATCH_COUNT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_cur, cnt_upd;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
`endif

  // Widen class lines so a 6-bit selector always indexes in range
  assign cls_ext = CLS_XW'(cls);

  // Next-state, hit detection, per-packet tracking and result handshake
  always_comb begin
    // sod restarts the packet before the current byte is processed
    s_cur     = sod ? '0 : s_q;
    cur_pos   = sod ? '0 : pos_q;
    match_cur = sod ? 1'b0 : match_q;
    fpos_cur  = sod ? POS_NONE : fpos_q;

    arm = (!ANCHORED || (cur_pos == '0)) ? START_MASK : '0;
    for (int i = 0; i < int'(NSTATE); i++) begin
      s_nxt[i] = cls_ext[CLASS_SEL[i*6 +: 6]] &
                 (arm[i] | (|(s_cur & PRED_MASK[i*NSTATE +: NSTATE])) |
                  (SELF_MASK[i] & s_cur[i]));
    end
    hit = |(s_nxt & ACCEPT_MASK);

    pos_inc   = (cur_pos == POS_NONE) ? cur_pos : cur_pos + POS_W'(1);
    fpos_upd  = (!match_cur && hit) ? cur_pos : fpos_cur;
    match_upd = match_cur | hit;
`ifdef NFA_MATCH_COUNT_EN
    cnt_cur = sod ? '0 : cnt_q;
    cnt_upd = (hit && (cnt_cur != CNT_MAX)) ? cnt_cur + CNT_W'(1) : cnt_cur;
    cnt_d     = cnt_q;
    res_cnt_d = res_cnt_q;
`endif

    s_d         = s_q;
    pos_d       = pos_q;
    fpos_d      = fpos_q;
    match_d     = match_q;
    res_valid_d = res_valid_q & ~res_ready;
    res_match_d = res_match_q;
    res_pos_d   = res_pos_q;
    res_drop_d  = 1'b0;

    if (en) begin
      if (eod) begin
        // Last byte: publish result (or drop it) and restart the packet
        s_d     = '0;
        pos_d   = '0;
        fpos_d  = POS_NONE;
        match_d = 1'b0;
`ifdef NFA_MATCH_COUNT_EN
        cnt_d = '0;
`endif
        if (!res_valid_q || res_ready) begin
          res_valid_d = 1'b1;
          res_match_d = match_upd;
          res_pos_d   = fpos_upd;
`ifdef NFA_MATCH_COUNT_EN
          res_cnt_d = cnt_upd;
`endif
        end else begin
          res_drop_d = 1'b1;
        end
      end else begin
        s_d     = s_nxt;
        pos_d   = pos_inc;
        fpos_d  = fpos_upd;
        match_d = match_upd;
`ifdef NFA_MATCH_COUNT_EN
        cnt_d = cnt_upd;
`endif
      end
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge sod_n) begin
    if (!sod_n) begin
      s_q         <= '0;
      pos_q       <= '0;
      fpos_q      <= POS_NONE;
      match_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_pos_q   <= '0;
      res_drop_q  <= 1'b0;
`ifdef NFA_MATCH_COUNT_EN
      cnt_q       <= '0;
      res_cnt_q   <= '0;
`endif
    end else begin
      s_q         <= s_d;
      pos_q       <= pos_d;
      fpos_q      <= fpos_d;
      match_q     <= match_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_pos_q   <= res_pos_d;
      res_drop_q  <= res_drop_d;
`ifdef NFA_MATCH_COUNT_EN
      cnt_q       <= cnt_d;
      res_cnt_q   <= res_cnt_d;
`endif
    end
  end

  assign match     = match_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_pos   = res_pos_q;
  assign res_drop  = res_drop_q;
`ifdef NFA_MATCH_COUNT_EN
  assign res_cnt   = res_cnt_q;
`else
  assign res_cnt   = '0;
`endif

endmodule

// File: tb/tb_nfa_engine_param.sv
// Directed bench for nfa_engine_param: chain a -> b(self) -> c, accept on c.
// A second, anchored instance shares the stimulus.
module tb_nfa_engine_param;

  localparam logic [3:0] A  = 4'b0001;
  localparam logic [3:0] B  = 4'b0010;
  localparam logic [3:0] C  = 4'b0100;
  localparam logic [3:0] X  = 4'b1000;
  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [15:0] NP = 16'hFFFF;
`ifdef NFA_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk, sod_n, sod, en, eod, res_ready;
  logic [3:0] cls;
  logic d_match, d_valid, d_rmatch, d_drop;
  logic [15:0] d_pos;
  logic [7:0]  d_cnt;
  logic a_match, a_valid, a_rmatch, a_drop;
  logic [15:0] a_pos;
  logic [7:0]  a_cnt;

  int n_chk = 0;
  int n_err = 0;

  nfa_engine_param #(
    .NSTATE(3), .NCLASS(4),
    .CLASS_SEL(18'b000010_000001_000000),
    .PRED_MASK(9'b010_001_000),
    .START_MASK(3'b001), .SELF_MASK(3'b010), .ACCEPT_MASK(3'b100),
    .ANCHORED(1'b0)
  ) u_dut (
    .clk(clk), .sod_n(sod_n), .sod(sod), .en(en), .eod(eod), .cls(cls),
    .match(d_match), .res_valid(d_valid), .res_ready(res_ready),
    .res_match(d_rmatch), .res_pos(d_pos), .res_cnt(d_cnt), .res_drop(d_drop)
  );

  nfa_engine_param #(
    .NSTATE(3), .NCLASS(4),
    .CLASS_SEL(18'b000010_000001_000000),
    .PRED_MASK(9'b010_001_000),
    .START_MASK(3'b001), .SELF_MASK(3'b010), .ACCEPT_MASK(3'b100),
    .ANCHORED(1'b1)
  ) u_anch (
    .clk(clk), .sod_n(sod_n), .sod(sod), .en(en), .eod(eod), .cls(cls),
    .match(a_match), .res_valid(a_valid), .res_ready(res_ready),
    .res_match(a_rmatch), .res_pos(a_pos), .res_cnt(a_cnt), .res_drop(a_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sod, en, eod;
    logic [3:0] cls;
    logic       rdy;
    logic       e_match, e_valid, e_rmatch;
    logic [15:0] e_pos;
    int         e_cnt;
    logic       e_drop;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic s, e, d, input logic [3:0] c,
                              input logic r, input logic m, v, rm,
                              input logic [15:0] p, input int n, input logic dr);
    vec_t t;
    t.sod = s; t.en = e; t.eod = d; t.cls = c; t.rdy = r;
    t.e_match = m; t.e_valid = v; t.e_rmatch = rm;
    t.e_pos = p; t.e_cnt = n; t.e_drop = dr;
    return t;
  endfunction

  function automatic logic [7:0] ec(input int n);
    return CNT_EN ? 8'(n) : 8'd0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input logic m, v, rm,
                         input logic [15:0] p, input int n, input logic dr);
    chk({tag, " match"},     16'(d_match),  16'(m));
    chk({tag, " res_valid"}, 16'(d_valid),  16'(v));
    chk({tag, " res_match"}, 16'(d_rmatch), 16'(rm));
    chk({tag, " res_pos"},   d_pos,         p);
    chk({tag, " res_cnt"},   16'(d_cnt),    16'(ec(n)));
    chk({tag, " res_drop"},  16'(d_drop),   16'(dr));
  endtask

  task automatic step(input logic s, e, d, input logic [3:0] c, input logic r);
    sod = s; en = e; eod = d; cls = c; res_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sod_n = 1'b0; sod = 1'b0; en = 1'b0; eod = 1'b0; cls = Z; res_ready = 1'b1;

    // sod, en, eod, cls, rdy | match, valid, rmatch, pos, cnt, drop
    // "x a b b b c": first hit at position 5
    tv.push_back(mk(1,1,0,X,1, 0,0,0,16'd0,0,0));
    tv.push_back(mk(0,1,0,A,1, 0,0,0,16'd0,0,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,0,16'd0,0,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,0,16'd0,0,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,0,16'd0,0,0));
    tv.push_back(mk(0,1,1,C,1, 0,1,1,16'd5,1,0));
    tv.push_back(mk(0,0,0,Z,1, 0,0,1,16'd5,1,0));
    // "acbc": no match
    tv.push_back(mk(0,1,0,A,1, 0,0,1,16'd5,1,0));
    tv.push_back(mk(0,1,0,C,1, 0,0,1,16'd5,1,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,1,16'd5,1,0));
    tv.push_back(mk(0,1,1,C,1, 0,1,0,NP,0,0));
    tv.push_back(mk(0,0,0,Z,1, 0,0,0,NP,0,0));
    // "ab" <idle with sod/eod ignored> "cabc": two hits, first at 2
    tv.push_back(mk(0,1,0,A,1, 0,0,0,NP,0,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,0,NP,0,0));
    tv.push_back(mk(1,0,1,C,1, 0,0,0,NP,0,0));
    tv.push_back(mk(0,1,0,C,1, 1,0,0,NP,0,0));
    tv.push_back(mk(0,1,0,A,1, 1,0,0,NP,0,0));
    tv.push_back(mk(0,1,0,B,1, 1,0,0,NP,0,0));
    tv.push_back(mk(0,1,1,C,1, 0,1,1,16'd2,2,0));
    tv.push_back(mk(0,0,0,Z,1, 0,0,1,16'd2,2,0));
    // "abc" then mid-packet sod clears match/state/count; "c" cannot match
    tv.push_back(mk(0,1,0,A,1, 0,0,1,16'd2,2,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,1,16'd2,2,0));
    tv.push_back(mk(0,1,0,C,1, 1,0,1,16'd2,2,0));
    tv.push_back(mk(1,1,0,X,1, 0,0,1,16'd2,2,0));
    tv.push_back(mk(0,1,1,C,1, 0,1,0,NP,0,0));
    tv.push_back(mk(0,0,0,Z,1, 0,0,0,NP,0,0));
    // back-pressure: second result dropped, first held
    tv.push_back(mk(0,1,0,A,0, 0,0,0,NP,0,0));
    tv.push_back(mk(0,1,0,B,0, 0,0,0,NP,0,0));
    tv.push_back(mk(0,1,1,C,0, 0,1,1,16'd2,1,0));
    tv.push_back(mk(0,1,1,X,0, 0,1,1,16'd2,1,1));
    tv.push_back(mk(0,0,0,Z,0, 0,1,1,16'd2,1,0));
    tv.push_back(mk(0,0,0,Z,1, 0,0,1,16'd2,1,0));
    // eod coinciding with a consumed result replaces it
    tv.push_back(mk(0,1,0,A,1, 0,0,1,16'd2,1,0));
    tv.push_back(mk(0,1,0,B,1, 0,0,1,16'd2,1,0));
    tv.push_back(mk(0,1,1,C,1, 0,1,1,16'd2,1,0));
    tv.push_back(mk(0,1,1,X,1, 0,1,0,NP,0,0));
    tv.push_back(mk(0,0,0,Z,1, 0,0,0,NP,0,0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_dut("reset", 0, 0, 0, 16'd0, 0, 0);
    #2 sod_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].sod, tv[i].en, tv[i].eod, tv[i].cls, tv[i].rdy);
      chk_dut($sformatf("row%0d", i), tv[i].e_match, tv[i].e_valid, tv[i].e_rmatch,
              tv[i].e_pos, tv[i].e_cnt, tv[i].e_drop);
    end

    // anchored: "xabc" must not match, "abc" matches at 2
    step(0,1,0,X,1);
    step(0,1,0,A,1);
    step(0,1,0,B,1);
    step(0,1,1,C,1);
    chk("anch1 res_valid", 16'(a_valid),  16'd1);
    chk("anch1 res_match", 16'(a_rmatch), 16'd0);
    chk("anch1 res_pos",   a_pos,         NP);
    chk("unanch res_match", 16'(d_rmatch), 16'd1);
    chk("unanch res_pos",   d_pos,         16'd3);
    step(0,1,0,A,1);
    step(0,1,0,B,1);
    step(0,1,1,C,1);
    chk("anch2 res_valid", 16'(a_valid),  16'd1);
    chk("anch2 res_match", 16'(a_rmatch), 16'd1);
    chk("anch2 res_pos",   a_pos,         16'd2);
    chk("anch2 res_cnt",   16'(a_cnt),    16'(ec(1)));
    step(0,0,0,Z,1);

    // asynchronous reset mid-packet after "ab"
    step(0,1,0,A,0);
    step(0,1,0,B,0);
    step(0,1,1,C,0);
    step(0,1,0,A,0);
    step(0,1,0,B,0);
    step(0,1,0,C,0);
    step(0,1,0,A,0);
    step(0,1,0,B,0);
    chk("prerst match",     16'(d_match), 16'd1);
    chk("prerst res_valid", 16'(d_valid), 16'd1);
    en = 1'b0;
    #3 sod_n = 1'b0;
    #1;
    chk_dut("async_rst", 0, 0, 0, 16'd0, 0, 0);
    #2 sod_n = 1'b1;
    step(0,1,1,C,1);
    chk_dut("post_rst", 0, 1, 0, NP, 0, 0);
    step(0,0,0,Z,1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
